// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared types for the instruction register and its
// front-end controller (opcode/operand/instruction words, FIFO sizing,
// request payload bundle).
package instr_register_pkg;

  // Number of entries in the instr_register array.
  parameter int IR_DEPTH = 32;
  localparam int IR_PTR_W = $clog2(IR_DEPTH);

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;
  typedef logic [IR_PTR_W-1:0] ptr_t;

  // One stored word as presented by instr_register.
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rslt;
  } instruction_t;

  // What a requester hands over when it is granted.
  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } req_payload_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter producing a one-hot grant.
// Build macro INSTR_CTRL_FIXED_PRIO_EN: when defined, requester 0 always wins
// and 'last' is ignored; otherwise round-robin, where the requester after
// 'last' (the index most recently granted) gets first chance.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef INSTR_CTRL_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: requester 0 beats requester 1 whenever both ask.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end
`else
  // Round-robin: whoever was not served last is looked at first.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (last) begin
        if (req[0]) begin
          gnt = 2'b01;
        end else if (req[1]) begin
          gnt = 2'b10;
        end
      end else begin
        if (req[1]) begin
          gnt = 2'b10;
        end else if (req[0]) begin
          gnt = 2'b01;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: front-end controller that uses the instr_register array as
// a FIFO shared by two requesters. Arbitrates writes, drives load_en and the
// write/read pointers, and drains stored words in write order over a
// valid/ready handshake.
// Build macro INSTR_CTRL_FIXED_PRIO_EN switches the arbiter from round-robin
// to fixed priority (requester 0 first).
//
// Timing of one write: grant in N, payload registered at end of N, load_en
// in N+1, array and wr_ptr/avail update at end of N+1, readable from N+2.
// 'used' counts from the grant so full/empty already include in-flight words;
// 'avail' counts only words that have actually landed in the array.
module instr_reg_ctrl
  import instr_register_pkg::*;
#(
  parameter int DEPTH = IR_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req,
  input  opcode_t      req_opcode [2],
  input  operand_t     req_op_a   [2],
  input  operand_t     req_op_b   [2],
  output logic [1:0]   gnt,
  input  logic         flush,
  output logic         load_en,
  output opcode_t      opcode,
  output operand_t     operand_a,
  output operand_t     operand_b,
  output address_t     write_pointer,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instr,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] used
);

  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   used_reg;
  logic [PTR_W:0]   used_next;
  logic [PTR_W:0]   avail_reg;
  logic [PTR_W:0]   avail_next;
  logic             last_gnt_reg;
  logic             load_en_reg;
  req_payload_t     payload_reg;
  req_payload_t     req_pl [2];

  logic arb_en;
  logic grant;
  logic commit;
  logic pop;

  // Bundle each requester's fields so the winner can be picked by index.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req_pl
      assign req_pl[gi] = '{opc: req_opcode[gi], a: req_op_a[gi], b: req_op_b[gi]};
    end
  endgenerate

  // Grants are offered only out of reset, with room left, and outside a flush.
  assign arb_en = reset_n & ~full & ~flush;

  rr_arb2 u_arb (
    .req  (req),
    .en   (arb_en),
    .last (last_gnt_reg),
    .gnt  (gnt)
  );

  assign grant  = |gnt;
  // A flush kills the write that was already on its way to the array.
  assign commit = load_en_reg & ~flush;
  assign pop    = out_valid & out_ready;

  assign load_en       = commit;
  assign opcode        = payload_reg.opc;
  assign operand_a     = payload_reg.a;
  assign operand_b     = payload_reg.b;
  assign write_pointer = address_t'(wr_ptr_reg);
  assign read_pointer  = address_t'(rd_ptr_reg);
  assign out_instr     = instruction_word;
  assign out_valid     = (avail_reg != '0);
  assign full          = (used_reg == CNT_DEPTH);
  assign empty         = (used_reg == '0);
  assign used          = used_reg;

  // Occupancy: grants add, pops remove, both together cancel out.
  always_comb begin
    used_next = used_reg;
    if (flush) begin
      used_next = '0;
    end else if (grant && !pop) begin
      used_next = used_reg + CNT_ONE;
    end else if (pop && !grant) begin
      used_next = used_reg - CNT_ONE;
    end
  end

  // Readable words: array commits add, pops remove, both together cancel out.
  always_comb begin
    avail_next = avail_reg;
    if (flush) begin
      avail_next = '0;
    end else if (commit && !pop) begin
      avail_next = avail_reg + CNT_ONE;
    end else if (pop && !commit) begin
      avail_next = avail_reg - CNT_ONE;
    end
  end

  // Capture the winning payload and schedule its write for the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      payload_reg <= '{opc: ZERO, a: '0, b: '0};
      load_en_reg <= 1'b0;
    end else begin
      load_en_reg <= grant;
      if (grant) begin
        payload_reg <= req_pl[gnt[1]];
      end
    end
  end

  // Remember who was served last; starts at 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_reg <= 1'b1;
    end else if (grant) begin
      last_gnt_reg <= gnt[1];
    end
  end

  // Write pointer advances with each committed write and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
    end else if (commit) begin
      wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
    end
  end

  // Read pointer advances with each pop and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
    end else if (pop) begin
      rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Occupancy and availability counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      used_reg  <= '0;
      avail_reg <= '0;
    end else begin
      used_reg  <= used_next;
      avail_reg <= avail_next;
    end
  end

endmodule
